mcpu_mem_arb: RTL and testbench

//  Shares the single LPDDR2 controller Avalon port (arb2mc_avl_*) among NCLIENTS requesters, using round-robin arbitration.
//  A grant is held for a whole command: one read command, or every beat of a write burst.

---
 rtl/mcpu_mem_pkg.sv | 20 ++
 rtl/mcpu_mem_arb_if.sv | 46 ++++
 rtl/mcpu_mem_tagfifo.sv | 58 +++++
 rtl/mcpu_mem_arb.sv | 168 ++++++++++++++++
 tb/tb_mcpu_mem_arb.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcpu_mem_pkg.sv
// Shared types and widths for the multi-client LPDDR2 Avalon arbiter.
package mcpu_mem_pkg;

  localparam int AVL_AW  = 25;
  localparam int AVL_DW  = 128;
  localparam int AVL_BEW = 16;
  localparam int AVL_SW  = 5;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } arb_state_e;

  // A zero burst length is treated as a single beat everywhere.
  function automatic logic [AVL_SW-1:0] eff_size(input logic [AVL_SW-1:0] size);
    return (size == '0) ? AVL_SW'(1) : size;
  endfunction

endpackage

// File: rtl/mcpu_mem_arb_if.sv
// Client-side command/read-return bus plus the controller Avalon port.
// master = arbiter view, slave = the clients and controller around it.
interface mcpu_mem_arb_if
  import mcpu_mem_pkg::*;
#(
  parameter int NCLIENTS = 2
) ();

  logic [NCLIENTS-1:0]              cli_valid;
  logic [NCLIENTS-1:0]              cli_we;
  logic [NCLIENTS-1:0][AVL_AW-1:0]  cli_addr;
  logic [NCLIENTS-1:0][AVL_SW-1:0]  cli_size;
  logic [NCLIENTS-1:0][AVL_DW-1:0]  cli_wdata;
  logic [NCLIENTS-1:0][AVL_BEW-1:0] cli_be;
  logic [NCLIENTS-1:0]              cli_ready;
  logic [NCLIENTS-1:0]              cli_rvalid;
  logic [AVL_DW-1:0]                cli_rdata;

  logic                             arb2mc_avl_ready_0;
  logic                             arb2mc_avl_rdata_valid_0;
  logic [AVL_DW-1:0]                arb2mc_avl_rdata_0;
  logic [AVL_AW-1:0]                arb2mc_avl_addr_0;
  logic [AVL_SW-1:0]                arb2mc_avl_size_0;
  logic [AVL_DW-1:0]                arb2mc_avl_wdata_0;
  logic [AVL_BEW-1:0]               arb2mc_avl_be_0;
  logic                             arb2mc_avl_read_req_0;
  logic                             arb2mc_avl_write_req_0;
  logic                             arb2mc_avl_burstbegin_0;

  modport master (
    input  cli_valid, cli_we, cli_addr, cli_size, cli_wdata, cli_be,
    output cli_ready, cli_rvalid, cli_rdata,
    input  arb2mc_avl_ready_0, arb2mc_avl_rdata_valid_0, arb2mc_avl_rdata_0,
    output arb2mc_avl_addr_0, arb2mc_avl_size_0, arb2mc_avl_wdata_0, arb2mc_avl_be_0,
    output arb2mc_avl_read_req_0, arb2mc_avl_write_req_0, arb2mc_avl_burstbegin_0
  );

  modport slave (
    output cli_valid, cli_we, cli_addr, cli_size, cli_wdata, cli_be,
    input  cli_ready, cli_rvalid, cli_rdata,
    output arb2mc_avl_ready_0, arb2mc_avl_rdata_valid_0, arb2mc_avl_rdata_0,
    input  arb2mc_avl_addr_0, arb2mc_avl_size_0, arb2mc_avl_wdata_0, arb2mc_avl_be_0,
    input  arb2mc_avl_read_req_0, arb2mc_avl_write_req_0, arb2mc_avl_burstbegin_0
  );

endinterface

// File: rtl/mcpu_mem_tagfifo.sv
// In-order tag FIFO for outstanding reads; supports push and pop in the same cycle.
module mcpu_mem_tagfifo #(
  parameter int W     = 6,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int unsigned DEPTH_U = DEPTH;
  localparam logic [AW:0] FULL_CNT = DEPTH_U[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define validity, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/mcpu_mem_arb.sv
// Round-robin arbiter sharing one LPDDR2 controller Avalon port among NCLIENTS,
// holding the grant for a whole command and steering read beats back via a tag FIFO.
module mcpu_mem_arb
  import mcpu_mem_pkg::*;
#(
  parameter int NCLIENTS  = 2,
  parameter int RDQ_DEPTH = 8
) (
  input  logic           clkrst_avl_clk,
  input  logic           clkrst_avl_rst,
  input  logic           mc_ready,
  output logic           err_unexp_rdata,
  mcpu_mem_arb_if.master bus
);

  localparam int CW = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;
  localparam int TW = CW + AVL_SW;
  localparam int unsigned NCLIENTS_U = NCLIENTS;
  localparam logic [CW:0] N_EXT = NCLIENTS_U[CW:0];

  arb_state_e          state, state_nxt;
  logic [CW-1:0]       gnt, gnt_nxt;
  logic [CW-1:0]       rr_ptr, rr_ptr_nxt;
  logic [AVL_SW-1:0]   wbeat, wbeat_nxt;
  logic [AVL_SW-1:0]   rbeat;
  logic [AVL_SW-1:0]   cur_size;
  logic                read_req, write_req, burstbegin;
  logic [NCLIENTS-1:0] cli_ready;
  logic [NCLIENTS-1:0] cli_rvalid;

  logic                rdq_push, rdq_pop, rdq_full, rdq_empty;
  logic [TW-1:0]       rdq_head;
  logic [CW-1:0]       head_id;
  logic [AVL_SW-1:0]   head_size;
  logic                rd_hit;

  logic [NCLIENTS-1:0]   eligible;
  logic [2*NCLIENTS-1:0] elig_rot;
  logic                  pick_found;
  logic [CW:0]           pick_off;
  logic [CW:0]           pick_sum;
  logic [CW-1:0]         pick;

  function automatic logic [CW-1:0] next_client(input logic [CW-1:0] c);
    if (c == CW'(NCLIENTS - 1)) return '0;
    return c + 1'b1;
  endfunction

  // Reads need a free tag slot; writes never touch the FIFO.
  assign eligible = bus.cli_valid & {NCLIENTS{mc_ready}} & (bus.cli_we | {NCLIENTS{~rdq_full}});
  assign elig_rot = {eligible, eligible} >> rr_ptr;
  assign cur_size = eff_size(bus.cli_size[gnt]);

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_off   = '0;
    for (int k = 0; k < NCLIENTS; k++) begin
      if (!pick_found && elig_rot[k]) begin
        pick_found = 1'b1;
        pick_off   = k[CW:0];
      end
    end
    pick_sum = {1'b0, rr_ptr} + pick_off;
    if (pick_sum >= N_EXT) pick_sum = pick_sum - N_EXT;
    pick = pick_sum[CW-1:0];
  end

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    rr_ptr_nxt = rr_ptr;
    wbeat_nxt  = wbeat;
    rdq_push   = 1'b0;
    read_req   = 1'b0;
    write_req  = 1'b0;
    burstbegin = 1'b0;
    cli_ready  = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          gnt_nxt   = pick;
          state_nxt = bus.cli_we[pick] ? WR : RD;
        end
      end
      RD: begin
        read_req   = 1'b1;
        burstbegin = 1'b1;
        if (bus.arb2mc_avl_ready_0) begin
          rdq_push       = 1'b1;
          cli_ready[gnt] = 1'b1;
          rr_ptr_nxt     = next_client(gnt);
          state_nxt      = IDLE;
        end
      end
      WR: begin
        write_req  = 1'b1;
        burstbegin = (wbeat == '0);
        if (bus.arb2mc_avl_ready_0) begin
          cli_ready[gnt] = 1'b1;
          if (wbeat == cur_size - 5'd1) begin
            wbeat_nxt  = '0;
            rr_ptr_nxt = next_client(gnt);
            state_nxt  = IDLE;
          end else begin
            wbeat_nxt = wbeat + 5'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read return: the FIFO head names the owner of every returning beat.
  assign {head_id, head_size} = rdq_head;
  assign rd_hit  = bus.arb2mc_avl_rdata_valid_0 & ~rdq_empty;
  assign rdq_pop = rd_hit & (rbeat == head_size - 5'd1);

  always_comb begin
    cli_rvalid = '0;
    if (rd_hit) cli_rvalid[head_id] = 1'b1;
  end

  always_ff @(posedge clkrst_avl_clk) begin
    if (clkrst_avl_rst) begin
      state           <= IDLE;
      gnt             <= '0;
      rr_ptr          <= '0;
      wbeat           <= '0;
      rbeat           <= '0;
      err_unexp_rdata <= 1'b0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      rr_ptr <= rr_ptr_nxt;
      wbeat  <= wbeat_nxt;
      if (rd_hit) rbeat <= rdq_pop ? '0 : rbeat + 5'd1;
      if (bus.arb2mc_avl_rdata_valid_0 && rdq_empty) err_unexp_rdata <= 1'b1;
    end
  end

  mcpu_mem_tagfifo #(
    .W     (TW),
    .DEPTH (RDQ_DEPTH)
  ) u_tagfifo (
    .clk       (clkrst_avl_clk),
    .rst       (clkrst_avl_rst),
    .push      (rdq_push),
    .push_data ({gnt, cur_size}),
    .pop       (rdq_pop),
    .pop_data  (rdq_head),
    .full      (rdq_full),
    .empty     (rdq_empty)
  );

  assign bus.cli_ready               = cli_ready;
  assign bus.cli_rvalid              = cli_rvalid;
  assign bus.cli_rdata               = bus.arb2mc_avl_rdata_0;
  assign bus.arb2mc_avl_addr_0       = bus.cli_addr[gnt];
  assign bus.arb2mc_avl_size_0       = cur_size;
  assign bus.arb2mc_avl_wdata_0      = bus.cli_wdata[gnt];
  assign bus.arb2mc_avl_be_0         = bus.cli_be[gnt];
  assign bus.arb2mc_avl_read_req_0   = read_req;
  assign bus.arb2mc_avl_write_req_0  = write_req;
  assign bus.arb2mc_avl_burstbegin_0 = burstbegin;

endmodule

// File: tb/tb_mcpu_mem_arb.sv
// Bench for mcpu_mem_arb: client/controller BFMs, a command-level reference model
// compared every cycle, and directed scenarios with hand-computed expectations.
module tb_mcpu_mem_arb;
  import mcpu_mem_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mc_ready = 1'b1;
  logic err;

  mcpu_mem_arb_if #(.NCLIENTS(N)) bus ();

  mcpu_mem_arb #(.NCLIENTS(N), .RDQ_DEPTH(DEPTH)) dut (
    .clkrst_avl_clk  (clk),
    .clkrst_avl_rst  (rst),
    .mc_ready        (mc_ready),
    .err_unexp_rdata (err),
    .bus             (bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int eff(input int s);
    return (s == 0) ? 1 : s;
  endfunction

  // ---------------- stimulus BFMs ----------------
  typedef struct {bit we; int addr; int size; int seed;} cmd_t;
  cmd_t cq[N][$];
  int   cb[N];
  bit   ready_toggle = 0;
  bit   ready_val = 1;
  bit   tog = 1;
  int   ret_cnt = 0;
  int   ret_seq = 0;
  logic [N-1:0] obs_ready;

  task automatic push_cmd(input int c, input bit we, input int addr, input int size, input int seed);
    cmd_t x;
    x.we = we; x.addr = addr; x.size = size; x.seed = seed;
    cq[c].push_back(x);
  endtask

  task automatic drive_pins();
    for (int i = 0; i < N; i++) begin
      if (cq[i].size() > 0) begin
        bus.cli_valid[i] = 1'b1;
        bus.cli_we[i]    = cq[i][0].we;
        bus.cli_addr[i]  = AVL_AW'(cq[i][0].addr);
        bus.cli_size[i]  = AVL_SW'(cq[i][0].size);
        bus.cli_wdata[i] = {32'(cq[i][0].seed), 32'(cb[i]), 32'(cq[i][0].addr), 32'(i)};
        bus.cli_be[i]    = 16'(cq[i][0].seed * 7 + cb[i] * 3 + 1);
      end else begin
        bus.cli_valid[i] = 1'b0;
        bus.cli_we[i]    = 1'b0;
        bus.cli_addr[i]  = '0;
        bus.cli_size[i]  = '0;
        bus.cli_wdata[i] = '0;
        bus.cli_be[i]    = '0;
      end
    end
    bus.arb2mc_avl_ready_0       = ready_toggle ? tog : ready_val;
    bus.arb2mc_avl_rdata_valid_0 = (ret_cnt > 0);
    bus.arb2mc_avl_rdata_0       = {64'hD00D_0000_CAFE_0000, 32'h0, 32'(ret_seq)};
  endtask

  task automatic advance_bfm();
    for (int i = 0; i < N; i++) begin
      if (obs_ready[i] && cq[i].size() > 0) begin
        if (!cq[i][0].we) begin
          void'(cq[i].pop_front());
        end else begin
          cb[i]++;
          if (cb[i] == eff(cq[i][0].size)) begin
            void'(cq[i].pop_front());
            cb[i] = 0;
          end
        end
      end
    end
    if (ret_cnt > 0) begin
      ret_cnt--;
      ret_seq++;
    end
    tog = ~tog;
  endtask

  // ---------------- reference model ----------------
  // m_kind: 0 no command owned, 1 read command owned, 2 write burst owned
  typedef struct {int id; int size;} tag_t;
  int   m_kind = 0, m_owner = 0, m_beat = 0, m_ptr = 0, m_rbeat = 0;
  bit   m_err = 0;
  tag_t m_tags[$];

  task automatic compare();
    logic [N-1:0] e_ready, e_rvalid;
    bit e_bb;
    e_ready  = '0;
    e_rvalid = '0;
    e_bb = (m_kind == 1) || (m_kind == 2 && m_beat == 0);
    if (m_kind != 0 && bus.arb2mc_avl_ready_0) e_ready[m_owner] = 1'b1;
    if (bus.arb2mc_avl_rdata_valid_0 && m_tags.size() > 0) e_rvalid[m_tags[0].id] = 1'b1;
    check("read_req",   bus.arb2mc_avl_read_req_0,   m_kind == 1);
    check("write_req",  bus.arb2mc_avl_write_req_0,  m_kind == 2);
    check("burstbegin", bus.arb2mc_avl_burstbegin_0, e_bb);
    check("cli_ready",  bus.cli_ready,  e_ready);
    check("cli_rvalid", bus.cli_rvalid, e_rvalid);
    check("err",        err,            m_err);
    if (m_kind != 0) begin
      check("avl_addr", bus.arb2mc_avl_addr_0, bus.cli_addr[m_owner]);
      check("avl_size", bus.arb2mc_avl_size_0, eff(int'(bus.cli_size[m_owner])));
    end
    if (m_kind == 2) begin
      check("avl_wdata", bus.arb2mc_avl_wdata_0, bus.cli_wdata[m_owner]);
      check("avl_be",    bus.arb2mc_avl_be_0,    bus.cli_be[m_owner]);
    end
    if (e_rvalid != '0) check("cli_rdata", bus.cli_rdata, bus.arb2mc_avl_rdata_0);
  endtask

  task automatic model_step();
    bit   full;
    tag_t t;
    full = (m_tags.size() >= DEPTH);
    if (rst) begin
      m_kind = 0; m_owner = 0; m_beat = 0; m_ptr = 0; m_rbeat = 0; m_err = 0;
      m_tags.delete();
      return;
    end
    if (bus.arb2mc_avl_rdata_valid_0) begin
      if (m_tags.size() > 0) begin
        m_rbeat++;
        if (m_rbeat == m_tags[0].size) begin
          void'(m_tags.pop_front());
          m_rbeat = 0;
        end
      end else begin
        m_err = 1;
      end
    end
    case (m_kind)
      0: if (mc_ready) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (m_kind == 0 && bus.cli_valid[i] && (bus.cli_we[i] || !full)) begin
            m_owner = i;
            m_kind  = bus.cli_we[i] ? 2 : 1;
            m_beat  = 0;
          end
        end
      end
      1: if (bus.arb2mc_avl_ready_0) begin
        t.id = m_owner; t.size = eff(int'(bus.cli_size[m_owner]));
        m_tags.push_back(t);
        m_ptr  = (m_owner + 1) % N;
        m_kind = 0;
      end
      default: if (bus.arb2mc_avl_ready_0) begin
        m_beat++;
        if (m_beat == eff(int'(bus.cli_size[m_owner]))) begin
          m_beat = 0;
          m_ptr  = (m_owner + 1) % N;
          m_kind = 0;
        end
      end
    endcase
  endtask

  // ---------------- observation for directed checks ----------------
  int acc_rd[N], acc_wr[N], rdy_cnt[N], rv_cnt[N], first_rd_cyc[N], first_rv_cyc[N];
  int last_wr_cyc, bb_acc, req_cycles, last_rd_size;
  logic s_rd, s_wr, s_err;
  logic [N-1:0] s_ready;

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin
      acc_rd[i] = 0; acc_wr[i] = 0; rdy_cnt[i] = 0; rv_cnt[i] = 0;
      first_rd_cyc[i] = -1; first_rv_cyc[i] = -1;
    end
    last_wr_cyc = -1; bb_acc = 0; req_cycles = 0; last_rd_size = -1;
  endtask

  task automatic observe();
    s_rd = bus.arb2mc_avl_read_req_0;
    s_wr = bus.arb2mc_avl_write_req_0;
    s_ready = bus.cli_ready;
    s_err = err;
    obs_ready = bus.cli_ready;
    if (s_rd || s_wr) req_cycles++;
    if (s_wr && bus.arb2mc_avl_ready_0 && bus.arb2mc_avl_burstbegin_0) bb_acc++;
    for (int i = 0; i < N; i++) begin
      if (bus.cli_ready[i]) rdy_cnt[i]++;
      if (s_rd && bus.cli_ready[i]) begin
        acc_rd[i]++;
        last_rd_size = int'(bus.arb2mc_avl_size_0);
        if (first_rd_cyc[i] < 0) first_rd_cyc[i] = cyc;
      end
      if (s_wr && bus.cli_ready[i]) begin
        acc_wr[i]++;
        last_wr_cyc = cyc;
      end
      if (bus.cli_rvalid[i]) begin
        rv_cnt[i]++;
        if (first_rv_cyc[i] < 0) first_rv_cyc[i] = cyc;
      end
    end
  endtask

  task automatic tick();
    drive_pins();
    @(negedge clk);
    compare();
    observe();
    model_step();
    @(posedge clk);
    #1;
    advance_bfm();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int t0;

  initial begin
    clear_stats();
    for (int i = 0; i < N; i++) cb[i] = 0;
    obs_ready = '0;
    @(posedge clk);
    #1;
    ticks(3);
    check("rst_read_req", s_rd, 1'b0);
    check("rst_write_req", s_wr, 1'b0);
    check("rst_cli_ready", s_ready, '0);
    check("rst_err", s_err, 1'b0);
    rst = 1'b0;

    // 1: reset in the middle of a 4-beat write burst
    clear_stats();
    push_cmd(0, 1, 'h40, 4, 1);
    for (int k = 0; k < 20 && acc_wr[0] < 2; k++) tick();
    check("t1_beats_before_rst", acc_wr[0], 2);
    cq[0].delete();
    cb[0] = 0;
    do_reset();
    tick();
    check("t1_read_req", s_rd, 1'b0);
    check("t1_write_req", s_wr, 1'b0);
    check("t1_cli_ready", s_ready, '0);
    ret_cnt = 1;
    ticks(2);
    check("t1_fifo_empty_err", s_err, 1'b1);
    check("t1_no_rvalid", rv_cnt[0] + rv_cnt[1], 0);
    do_reset();
    tick();
    check("t1_err_cleared", s_err, 1'b0);

    // 2: two simultaneous reads, round robin from client 0
    clear_stats();
    t0 = cyc;
    push_cmd(0, 0, 'h100, 4, 0);
    push_cmd(1, 0, 'h200, 4, 0);
    for (int k = 0; k < 20 && acc_rd[1] == 0; k++) tick();
    check("t2_c0_cmd_cycle", first_rd_cyc[0], t0 + 1);
    check("t2_c1_cmd_cycle", first_rd_cyc[1], t0 + 3);
    ret_cnt = 8;
    ticks(12);
    check("t2_rv0", rv_cnt[0], 4);
    check("t2_rv1", rv_cnt[1], 4);
    check("t2_rv_order", first_rv_cyc[1], first_rv_cyc[0] + 4);

    // 3: write burst under a toggling ready, competing read waits
    clear_stats();
    push_cmd(1, 1, 'h300, 4, 3);
    tick();
    push_cmd(0, 0, 'h180, 1, 0);
    ready_toggle = 1;
    for (int k = 0; k < 40 && acc_wr[1] < 4; k++) tick();
    check("t3_wr_beats", acc_wr[1], 4);
    check("t3_ready_pulses", rdy_cnt[1], 4);
    check("t3_burstbegin_beats", bb_acc, 1);
    check("t3_c0_waited", acc_rd[0], 0);
    ready_toggle = 0;
    for (int k = 0; k < 10 && acc_rd[0] == 0; k++) tick();
    check("t3_c0_after_idle", first_rd_cyc[0], last_wr_cyc + 2);
    ret_cnt = 1;
    ticks(3);
    check("t3_c0_rv", rv_cnt[0], 1);

    // 4: tag FIFO full blocks reads but not writes
    clear_stats();
    for (int k = 0; k < 9; k++) push_cmd(1, 0, 'h400 + k, 1, 0);
    ticks(30);
    check("t4_reads_issued", acc_rd[1], 8);
    push_cmd(0, 1, 'h500, 2, 4);
    for (int k = 0; k < 10 && acc_wr[0] < 2; k++) tick();
    check("t4_write_granted", acc_wr[0], 2);
    check("t4_read_still_stalled", acc_rd[1], 8);
    ret_cnt = 1;
    for (int k = 0; k < 10 && acc_rd[1] < 9; k++) tick();
    check("t4_ninth_read", acc_rd[1], 9);
    ret_cnt = 8;
    ticks(12);
    check("t4_rv1", rv_cnt[1], 9);

    // 5: mc_ready gating
    clear_stats();
    mc_ready = 1'b0;
    push_cmd(0, 0, 'h600, 2, 0);
    ticks(5);
    check("t5_no_req", req_cycles, 0);
    mc_ready = 1'b1;
    for (int k = 0; k < 10 && acc_rd[0] == 0; k++) tick();
    check("t5_read_after_ready", acc_rd[0], 1);
    push_cmd(1, 1, 'h700, 4, 5);
    for (int k = 0; k < 10 && acc_wr[1] < 1; k++) tick();
    mc_ready = 1'b0;
    push_cmd(0, 0, 'h680, 1, 0);
    ticks(10);
    check("t5_burst_completes", acc_wr[1], 4);
    check("t5_read_blocked", acc_rd[0], 1);
    mc_ready = 1'b1;
    for (int k = 0; k < 10 && acc_rd[0] < 2; k++) tick();
    check("t5_read_resumed", acc_rd[0], 2);
    ret_cnt = 3;
    ticks(6);
    check("t5_rv0", rv_cnt[0], 3);

    // 6: size-0 read and unexpected read data
    clear_stats();
    push_cmd(0, 0, 'h7F0, 0, 0);
    for (int k = 0; k < 10 && acc_rd[0] == 0; k++) tick();
    check("t6_size0_clamped", last_rd_size, 1);
    ret_cnt = 1;
    ticks(3);
    check("t6_size0_rv", rv_cnt[0], 1);
    check("t6_err_clear", s_err, 1'b0);
    ret_cnt = 1;
    ticks(3);
    check("t6_unexp_no_rv", rv_cnt[0] + rv_cnt[1], 1);
    check("t6_err_set", s_err, 1'b1);
    ticks(5);
    check("t6_err_sticky", s_err, 1'b1);
    do_reset();
    tick();
    check("t6_err_reset", s_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
